// File: rtl/irq_pending_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending_arbiter
// Purpose  : Captures rising edges on 8 interrupt lines into a sticky pending
//            register. Presents the highest-priority unmasked pending line
//            (bit 7 highest) as a 3-bit id with a valid/ack handshake.
// Config   : Define IRQ_SYNC_EN to put a SYNC_STAGES-flop synchronizer on each
//            line. When it is undefined, irq_in must already be synchronous to
//            clk.
// Revision : 1.0 - initial release
// ============================================================================
module irq_pending_arbiter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       clr_all,
  input  logic       ack,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // Lines that are already high when reset releases must not produce events.
  // Edge detection is therefore held off until the line history has filled
  // with post-reset samples. With the synchronizer, this takes the chain
  // depth plus the previous-sample flop.
`ifdef IRQ_SYNC_EN
  localparam int WARM = SYNC_STAGES + 1;
`else
  localparam int WARM = 1;
`endif
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);

  logic [7:0]        line_s;
  logic [7:0]        line_prev;
  logic [7:0]        evt;
  logic [7:0]        req;
  logic [7:0]        clr_vec;
  logic [2:0]        top_id;
  logic [WARM_W-1:0] warm_cnt;
  logic              armed;
  state_t            state;

`ifdef IRQ_SYNC_EN
  logic [7:0] sync_q [SYNC_STAGES];

  // Multi-flop synchronizer per interrupt line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign line_s = sync_q[SYNC_STAGES-1];
`else
  assign line_s = irq_in;
`endif

  assign armed = (warm_cnt == WARM_W'(WARM));
  assign evt   = armed ? (line_s & ~line_prev) : 8'h00;
  assign req   = pending & mask;

  // Previous line sample and post-reset warm-up counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_prev <= '0;
      warm_cnt  <= '0;
    end else begin
      line_prev <= line_s;
      if (!armed) warm_cnt <= warm_cnt + WARM_W'(1);
    end
  end

  // Bit to retire when the presented id is accepted
  always_comb begin
    clr_vec = 8'h00;
    if (irq_valid && ack) clr_vec = 8'h01 << irq_id;
  end

  // Highest set bit of the unmasked requests; the later loop iterations win
  always_comb begin
    top_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) top_id = 3'(i);
    end
  end

  // Sticky pending register; a fresh event beats both ack-clear and clr_all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 8'h00;
    else if (clr_all) pending <= evt;
    else pending <= (pending & ~clr_vec) | evt;
  end

  // Present/accept handshake; the id is frozen while presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      irq_valid <= 1'b0;
      irq_id    <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            irq_id    <= top_id;
            irq_valid <= 1'b1;
            state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ack || clr_all) begin
            irq_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_pending_arbiter
// Purpose  : Directed bench for irq_pending_arbiter. It uses a cycle-level
//            reference model and hand-computed checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_pending_arbiter;

`ifdef IRQ_SYNC_EN
  localparam int D = 2;   // synchronizer delay in edges
`else
  localparam int D = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irq_in = 8'hFF;
  logic [7:0] mask = 8'hFF;
  logic       clr_all = 1'b0;
  logic       ack = 1'b0;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;

  int total = 0;
  int bad = 0;

  irq_pending_arbiter #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask(mask),
    .clr_all(clr_all), .ack(ack), .irq_valid(irq_valid),
    .irq_id(irq_id), .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: line history per edge, pending set, presented id
  logic [7:0] m_pend = 8'h00;
  logic       m_valid = 1'b0;
  logic [2:0] m_id = 3'd0;
  int         n_edges = 0;
  logic [7:0] hist[$];

  function automatic logic [2:0] highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] ev, clr, nxt;
    if (!rst_n) begin
      m_pend = 8'h00; m_valid = 1'b0; m_id = 3'd0; n_edges = 0;
      hist.delete();
    end else begin
      n_edges++;
      hist.push_front(irq_in);
      if (hist.size() > D + 2) void'(hist.pop_back());
      ev = 8'h00;
      if (n_edges > D + 1) ev = hist[D] & ~hist[D+1];
      clr = (m_valid && ack) ? (8'h01 << m_id) : 8'h00;
      nxt = clr_all ? ev : ((m_pend & ~clr) | ev);
      if (!m_valid) begin
        if ((m_pend & mask) != 8'h00) begin
          m_id = highest(m_pend & mask);
          m_valid = 1'b1;
        end
      end else if (ack || clr_all) begin
        m_valid = 1'b0;
      end
      m_pend = nxt;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    total++;
    if (irq_valid !== m_valid || pending !== m_pend || (m_valid && irq_id !== m_id)) begin
      bad++;
      $display("FAIL cycle_cmp t=%0t: dut valid=%b id=%0d pend=%h, model valid=%b id=%0d pend=%h",
               $time, irq_valid, irq_id, pending, m_valid, m_id, pending === m_pend ? pending : m_pend);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int bound);
    int n = 0;
    while (irq_valid !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (irq_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s: irq_valid=%b after %0d cycles, expected 1", name, irq_valid, bound);
    end
  endtask

  task automatic pulse(input logic [7:0] bits);
    irq_in = bits;
    tick(1);
    irq_in = 8'h00;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    // 1. Reset with all lines high, then release: no event expected
    tick(2);
    chk("rst_pending", 32'(pending), 32'h00);
    chk("rst_valid", 32'(irq_valid), 32'h0);
    chk("rst_id", 32'(irq_id), 32'h0);
    rst_n = 1'b1;
    tick(6);
    chk("held_high_pending", 32'(pending), 32'h00);
    chk("held_high_valid", 32'(irq_valid), 32'h0);
    irq_in = 8'h00;
    tick(4);

    // 2. Single event on bit 5
    pulse(8'h20);
    tick(D);
    chk("single_pending", 32'(pending), 32'h20);
    chk("single_valid_early", 32'(irq_valid), 32'h0);
    tick(1);
    chk("single_valid", 32'(irq_valid), 32'h1);
    chk("single_id", 32'(irq_id), 32'h5);
    do_ack();
    chk("single_ack_pending", 32'(pending), 32'h00);
    chk("single_ack_valid", 32'(irq_valid), 32'h0);
    tick(2);

    // 3. Priority order 6, 4, 1, each separated by one idle cycle
    pulse(8'h52);
    wait_valid("prio_first", 10);
    chk("prio_id0", 32'(irq_id), 32'h6);
    do_ack();
    chk("prio_gap0", 32'(irq_valid), 32'h0);
    tick(1);
    chk("prio_id1", 32'(irq_id), 32'h4);
    chk("prio_valid1", 32'(irq_valid), 32'h1);
    do_ack();
    chk("prio_gap1", 32'(irq_valid), 32'h0);
    tick(1);
    chk("prio_id2", 32'(irq_id), 32'h1);
    do_ack();
    chk("prio_empty", 32'(pending), 32'h00);
    tick(2);

    // 4. Mask holds bit 7 back until unmasked
    mask = 8'h7F;
    pulse(8'h84);
    wait_valid("mask_first", 10);
    chk("mask_id", 32'(irq_id), 32'h2);
    do_ack();
    chk("mask_pending7", 32'(pending), 32'h80);
    tick(2);
    chk("mask_held", 32'(irq_valid), 32'h0);
    mask = 8'hFF;
    wait_valid("mask_unmask", 5);
    chk("mask_id7", 32'(irq_id), 32'h7);
    do_ack();
    tick(2);

    // 5. Set wins: new edge on bit 3 lands in the ack cycle of id 3
    pulse(8'h08);
    wait_valid("setwin_first", 10);
    chk("setwin_id", 32'(irq_id), 32'h3);
    irq_in = 8'h08;
    if (D == 0) ack = 1'b1;
    tick(1);
    irq_in = 8'h00;
    if (D > 0) begin
      tick(D - 1);
      ack = 1'b1;
      tick(1);
    end
    ack = 1'b0;
    chk("setwin_pending", 32'(pending), 32'h08);
    chk("setwin_gap", 32'(irq_valid), 32'h0);
    tick(1);
    chk("setwin_again", 32'(irq_valid), 32'h1);
    chk("setwin_id2", 32'(irq_id), 32'h3);
    do_ack();
    tick(2);

    // 6a. clr_all aborts a presented request
    pulse(8'h01);
    wait_valid("abort_first", 10);
    clr_all = 1'b1;
    tick(1);
    clr_all = 1'b0;
    chk("abort_valid", 32'(irq_valid), 32'h0);
    chk("abort_pending", 32'(pending), 32'h00);
    tick(2);

    // 6b. Asynchronous reset mid-handshake
    pulse(8'h02);
    wait_valid("rst_mid_first", 10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(irq_valid), 32'h0);
    chk("rst_mid_pending", 32'(pending), 32'h00);
    chk("rst_mid_id", 32'(irq_id), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_pending", 32'(pending), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
